// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Command layout as stored in the FIFO: {we, sel, adr, dat}
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  localparam int          CMD_W       = 69;
  localparam logic [31:0] TIMEOUT_DAT = 32'h0;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO with registered storage and extra-bit pointers for full/empty.
module wb_cmd_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage: no reset needed, contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; callers never push when full or pop when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat master: drains a command FIFO, one bus cycle
// and one response per command, with an ack timeout.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e                      state, state_nxt;
  cmd_t                        cmd_in, cmd_head, bus_q;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        push, pop, ack_done, tmo_done;
  logic [15:0]                 tmo_cnt;

  assign cmd_in    = {cmd_we, cmd_sel, cmd_adr, cmd_dat};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) | (fifo_count != '0);

  assign wbm_we_o  = bus_q.we;
  assign wbm_sel_o = bus_q.sel;
  assign wbm_adr_o = bus_q.adr;
  assign wbm_dat_o = bus_q.dat;

  wb_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (cmd_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control; ack takes priority over timeout expiry.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ack_done  = 1'b0;
    tmo_done  = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: if (wbm_ack_i) begin
        ack_done  = 1'b1;
        state_nxt = ST_RSP;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_done  = 1'b1;
        state_nxt = ST_RSP;
      end
      ST_RSP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus, timeout counter and response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_q     <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      if (pop) begin
        bus_q     <= cmd_head;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        tmo_cnt   <= '0;
      end
      if (state == ST_REQ && !ack_done && !tmo_done) tmo_cnt <= tmo_cnt + 1'b1;
      if (ack_done || tmo_done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= tmo_done;
        rsp_dat   <= (ack_done && !bus_q.we) ? wbm_dat_i : TIMEOUT_DAT;
      end
      if (state == ST_RSP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
